voice_alloc: RTL and testbench

Polyphonic voice allocator between the MIDI decoder and the bank of per-voice oscillators. It turns note-on/note-off events into one-hot channel strobes that start or stop individual oscillators. It tracks which note each voice holds and retriggers a repeated note on its own voice. When all voices are busy it steals the oldest one. It drives the note number to the shared period lookup table, so the selected oscillator latches the correct half-period on its strobe.

---
 rtl/voice_alloc_if.sv | 26 ++
 rtl/voice_alloc.sv | 143 ++++++++++++++
 tb/tb_voice_alloc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/voice_alloc_if.sv
// Event bus between the MIDI decoder, the voice allocator and the oscillator bank.
// Input strobes are one-cycle events taken only while busy_o is low; output strobes pulse for one cycle with ch_o.
interface voice_alloc_if #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BW    = 7
);
  logic                  noteOnStrb_i;
  logic                  noteOffStrb_i;
  logic [NOTE_BW-1:0]    note_i;
  logic                  busy_o;
  logic                  noteOnStrb_o;
  logic                  noteOffStrb_o;
  logic [NUM_VOICES-1:0] ch_o;
  logic [NOTE_BW-1:0]    note_o;
  logic                  stolen_o;

  modport master (
    output noteOnStrb_i, noteOffStrb_i, note_i,
    input  busy_o, noteOnStrb_o, noteOffStrb_o, ch_o, note_o, stolen_o
  );

  modport slave (
    input  noteOnStrb_i, noteOffStrb_i, note_i,
    output busy_o, noteOnStrb_o, noteOffStrb_o, ch_o, note_o, stolen_o
  );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events to one-hot oscillator strobes,
// retriggering held notes and stealing the oldest voice when all are busy.
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BW    = 7,
  parameter int AGE_BW     = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  voice_alloc_if.slave bus,
  output logic [1:0]  state_o
);
  localparam int IDX_BW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, ISSUE = 2'd2} state_t;
  // Candidate quality, ordered so a better kind has a larger code.
  typedef enum logic [1:0] {K_NONE = 2'd0, K_STEAL = 2'd1, K_FREE = 2'd2, K_MATCH = 2'd3} kind_t;

  state_t                state_q;
  kind_t                 kind_q, nxt_kind;
  logic [IDX_BW-1:0]     idx_q, cand_q, nxt_cand;
  logic [AGE_BW-1:0]     cand_age_q, nxt_cand_age;
  logic                  op_on_q;
  logic [NUM_VOICES-1:0] alloc_q;
  logic [NOTE_BW-1:0]    vnote_q [NUM_VOICES];
  logic [AGE_BW-1:0]     age_q   [NUM_VOICES];
  logic                  busy_q, on_strb_q, off_strb_q, stolen_q;
  logic [NUM_VOICES-1:0] ch_q;
  logic [NOTE_BW-1:0]    note_q;
  logic                  hit;

  always_comb begin
    nxt_kind     = kind_q;
    nxt_cand     = cand_q;
    nxt_cand_age = cand_age_q;
    hit          = alloc_q[idx_q] && (vnote_q[idx_q] == note_q);
    if (op_on_q) begin
      if (hit && kind_q != K_MATCH) begin
        nxt_kind = K_MATCH;
        nxt_cand = idx_q;
      end else if (!alloc_q[idx_q] && (kind_q == K_NONE || kind_q == K_STEAL)) begin
        nxt_kind = K_FREE;
        nxt_cand = idx_q;
      end else if (alloc_q[idx_q] &&
                   (kind_q == K_NONE || (kind_q == K_STEAL && age_q[idx_q] > cand_age_q))) begin
        nxt_kind     = K_STEAL;
        nxt_cand     = idx_q;
        nxt_cand_age = age_q[idx_q];
      end
    end else if (hit && kind_q == K_NONE) begin
      nxt_kind = K_MATCH;
      nxt_cand = idx_q;
    end
  end

  // Strobes, ch_o and the voice tables are all updated on the edge that enters ISSUE,
  // using the candidate that includes the last scanned voice.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= IDLE;
      kind_q     <= K_NONE;
      idx_q      <= '0;
      cand_q     <= '0;
      cand_age_q <= '0;
      op_on_q    <= 1'b0;
      alloc_q    <= '0;
      busy_q     <= 1'b0;
      on_strb_q  <= 1'b0;
      off_strb_q <= 1'b0;
      stolen_q   <= 1'b0;
      ch_q       <= '0;
      note_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vnote_q[v] <= '0;
        age_q[v]   <= '0;
      end
    end else begin
      on_strb_q  <= 1'b0;
      off_strb_q <= 1'b0;
      stolen_q   <= 1'b0;
      ch_q       <= '0;
      case (state_q)
        IDLE: begin
          if (bus.noteOffStrb_i || bus.noteOnStrb_i) begin
            note_q     <= bus.note_i;
            op_on_q    <= !bus.noteOffStrb_i;
            idx_q      <= '0;
            kind_q     <= K_NONE;
            cand_q     <= '0;
            cand_age_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          kind_q     <= nxt_kind;
          cand_q     <= nxt_cand;
          cand_age_q <= nxt_cand_age;
          idx_q      <= idx_q + IDX_BW'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= ISSUE;
            if (op_on_q) begin
              on_strb_q <= 1'b1;
              ch_q      <= NUM_VOICES'(1) << nxt_cand;
              stolen_q  <= (nxt_kind == K_STEAL);
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (IDX_BW'(v) == nxt_cand) begin
                  alloc_q[v] <= 1'b1;
                  vnote_q[v] <= note_q;
                  age_q[v]   <= '0;
                end else if (alloc_q[v] && age_q[v] != '1) begin
                  age_q[v] <= age_q[v] + AGE_BW'(1);
                end
              end
            end else if (nxt_kind == K_MATCH) begin
              off_strb_q       <= 1'b1;
              ch_q             <= NUM_VOICES'(1) << nxt_cand;
              alloc_q[nxt_cand] <= 1'b0;
              age_q[nxt_cand]   <= '0;
            end
          end
        end
        ISSUE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.noteOnStrb_o  = on_strb_q;
  assign bus.noteOffStrb_o = off_strb_q;
  assign bus.ch_o          = ch_q;
  assign bus.note_o        = note_q;
  assign bus.stolen_o      = stolen_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed plus randomized bench for voice_alloc against an array-based allocation model.
module tb_voice_alloc;
  localparam int N   = 4;
  localparam int NB  = 7;
  localparam int AB  = 4;
  localparam int MAX_AGE = (1 << AB) - 1;

  logic       clk_i;
  logic       nrst_i;
  logic [1:0] state_o;
  int         total;
  int         bad;

  voice_alloc_if #(.NUM_VOICES(N), .NOTE_BW(NB)) bus ();

  voice_alloc #(.NUM_VOICES(N), .NOTE_BW(NB), .AGE_BW(AB)) dut (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .bus    (bus),
    .state_o(state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: what each voice holds, by plain arrays.
  bit m_alloc [N];
  int m_note  [N];
  int m_age   [N];

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_alloc[i] = 0; m_note[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void model_event(input bit on, input bit off, input int note,
                                      output bit e_on, output bit e_off,
                                      output int e_ch, output bit e_stl);
    int c;
    e_on = 0; e_off = 0; e_ch = 0; e_stl = 0; c = -1;
    if (off) begin
      for (int i = 0; i < N; i++)
        if (c < 0 && m_alloc[i] && m_note[i] == note) c = i;
      if (c >= 0) begin
        e_off = 1; e_ch = 1 << c;
        m_alloc[c] = 0; m_age[c] = 0;
      end
    end else if (on) begin
      for (int i = 0; i < N; i++)
        if (c < 0 && m_alloc[i] && m_note[i] == note) c = i;
      if (c < 0)
        for (int i = 0; i < N; i++)
          if (c < 0 && !m_alloc[i]) c = i;
      if (c < 0) begin
        e_stl = 1; c = 0;
        for (int i = 1; i < N; i++)
          if (m_age[i] > m_age[c]) c = i;
      end
      for (int i = 0; i < N; i++)
        if (i != c && m_alloc[i] && m_age[i] < MAX_AGE) m_age[i]++;
      m_alloc[c] = 1; m_note[c] = note; m_age[c] = 0;
      e_on = 1; e_ch = 1 << c;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One event through the full latency window; optionally fires extra strobes while busy.
  task automatic do_event(input bit on, input bit off, input int note, input bit inject);
    bit e_on, e_off, e_stl;
    int e_ch;
    model_event(on, off, note, e_on, e_off, e_ch, e_stl);
    @(negedge clk_i);
    bus.noteOnStrb_i  = on;
    bus.noteOffStrb_i = off;
    bus.note_i        = NB'(note);
    @(posedge clk_i);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        bus.noteOnStrb_i = 0; bus.noteOffStrb_i = 0;
      end
      if (inject && k == 2) begin
        bus.noteOnStrb_i  = 1;
        bus.noteOffStrb_i = 1'($urandom_range(0, 1));
        bus.note_i        = NB'($urandom_range(0, 127));
      end
      if (k == 3) begin
        bus.noteOnStrb_i = 0; bus.noteOffStrb_i = 0;
      end
      check("busy", 32'(bus.busy_o), 32'd1);
      if (k == N + 1) begin
        check("on_strb", 32'(bus.noteOnStrb_o), 32'(e_on));
        check("off_strb", 32'(bus.noteOffStrb_o), 32'(e_off));
        check("ch", 32'(bus.ch_o), 32'(e_ch));
        check("stolen", 32'(bus.stolen_o), 32'(e_stl));
        check("note_o", 32'(bus.note_o), 32'(note));
      end else begin
        check("ch_quiet", 32'(bus.ch_o), 32'd0);
      end
    end
    @(negedge clk_i);
    check("busy_end", 32'(bus.busy_o), 32'd0);
    check("ch_end", 32'(bus.ch_o), 32'd0);
    check("note_hold", 32'(bus.note_o), 32'(note));
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    bus.noteOnStrb_i = 0; bus.noteOffStrb_i = 0; bus.note_i = '0;
    nrst_i = 0;
    model_clear();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_on", 32'(bus.noteOnStrb_o), 32'd0);
    check("rst_off", 32'(bus.noteOffStrb_o), 32'd0);
    check("rst_ch", 32'(bus.ch_o), 32'd0);
    check("rst_note", 32'(bus.note_o), 32'd0);
    check("rst_stolen", 32'(bus.stolen_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    nrst_i = 1;

    // Fill all voices, then steal the oldest.
    do_event(1, 0, 60, 0);
    do_event(1, 0, 62, 0);
    do_event(1, 0, 64, 0);
    do_event(1, 0, 67, 0);
    do_event(1, 0, 69, 0);
    // Retrigger, then release twice.
    do_event(1, 0, 62, 0);
    do_event(0, 1, 62, 0);
    do_event(0, 1, 62, 0);
    // Simultaneous on/off: off wins; strobes while busy are ignored.
    do_event(1, 1, 64, 1);
    do_event(1, 0, 71, 1);
    do_event(1, 0, 72, 0);
    // Saturate the ages of the untouched voices, then steal among ties.
    for (int i = 0; i < 20; i++) do_event(1, 0, 72, 0);
    do_event(1, 0, 40, 0);
    do_event(1, 0, 41, 0);

    // Randomized traffic over a small note range to force collisions.
    for (int i = 0; i < 80; i++) begin
      n = $urandom_range(58, 66);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_event(1, 0, n, 1'($urandom_range(0, 1)));
        5, 6, 7, 8:    do_event(0, 1, n, 1'($urandom_range(0, 1)));
        default:       do_event(1, 1, n, 0);
      endcase
    end

    // Reset in the middle of a scan.
    do_event(1, 0, 30, 0);
    @(negedge clk_i);
    bus.noteOnStrb_i = 1; bus.note_i = NB'(33);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.noteOnStrb_i = 0;
    @(negedge clk_i);
    check("scan_state", 32'(state_o), 32'd1);
    nrst_i = 0;
    #1;
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_on", 32'(bus.noteOnStrb_o), 32'd0);
    check("mid_rst_ch", 32'(bus.ch_o), 32'd0);
    check("mid_rst_note", 32'(bus.note_o), 32'd0);
    check("mid_rst_state", 32'(state_o), 32'd0);
    model_clear();
    @(negedge clk_i);
    nrst_i = 1;
    do_event(0, 1, 30, 0);
    do_event(1, 0, 50, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
